// File: rtl/pe_group_feeder_pkg.sv
// Shared definitions for the PE group feeder and the PE it drives:
// operand geometry, result widths and the feeder FSM state encoding.
package pe_group_feeder_pkg;

    localparam int CELL_BIT = 8;
    localparam int N_CELL   = 9;
    localparam int BIAS_W   = 16;
    localparam int OUT_W    = 8;
    localparam int CHUNK_W  = CELL_BIT * N_CELL;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        ISSUE,
        WAIT
    } feeder_state_t;

endpackage

// File: rtl/pe_group_feeder_chunk_buf.sv
// Chunk register file for one operand group: one write port, one
// asynchronous read port. Data is not reset; the FSM never reads unwritten slots.
module pe_chunk_buf #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 144,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pe_group_feeder.sv
// Collects one operand group plus its config, streams it to the PE on
// contiguous pe_en cycles, then captures and holds the PE result.
module pe_group_feeder
    import pe_group_feeder_pkg::*;
#(
    parameter int MAX_CHUNK = 8,
    parameter int TMO       = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [2:0]         cfg_step,
    input  logic [2:0]         cfg_bound,
    input  logic [BIAS_W-1:0]  cfg_bias,
    input  logic               chk_valid,
    output logic               chk_ready,
    input  logic [CHUNK_W-1:0] chk_in,
    input  logic [CHUNK_W-1:0] chk_weight,
    output logic [CHUNK_W-1:0] pe_in,
    output logic [CHUNK_W-1:0] pe_weight,
    output logic [BIAS_W-1:0]  pe_bias,
    output logic [2:0]         pe_bound,
    output logic [2:0]         pe_step,
    output logic               pe_en,
    input  logic [OUT_W-1:0]   pe_out,
    input  logic               pe_out_en,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [OUT_W-1:0]   res_data,
    output logic               err
);

    localparam int IDX_W  = $clog2(MAX_CHUNK);
    localparam int TCNT_W = $clog2(TMO + 3);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TMO + 2);

    feeder_state_t state, state_next;

    logic [2:0]           step_q;
    logic [2:0]           bound_q;
    logic [BIAS_W-1:0]    bias_q;
    logic [IDX_W-1:0]     wcnt;
    logic [IDX_W-1:0]     rcnt;
    logic [TCNT_W-1:0]    tcnt;
    logic [2*CHUNK_W-1:0] rd_data;

    logic cfg_fire;
    logic chk_fire;
    logic wcnt_last;
    logic rcnt_last;
    logic tmo_hit;

    // Handshakes are gated by reset so every output reads 0 while reset is held.
    assign cfg_ready = reset && (state == IDLE) && !res_valid;
    assign chk_ready = reset && (state == FILL);
    assign cfg_fire  = cfg_valid && cfg_ready;
    assign chk_fire  = chk_valid && chk_ready;
    assign wcnt_last = (wcnt == IDX_W'(step_q));
    assign rcnt_last = (rcnt == IDX_W'(step_q));
    assign tmo_hit   = (tcnt == TCNT_LAST);

    pe_chunk_buf #(
        .DEPTH (MAX_CHUNK),
        .WIDTH (2 * CHUNK_W)
    ) u_buf (
        .clk     (clk),
        .wr_en   (chk_fire),
        .wr_addr (wcnt),
        .wr_data ({chk_in, chk_weight}),
        .rd_addr (rcnt),
        .rd_data (rd_data)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cfg_fire) state_next = FILL;
            FILL:    if (chk_fire && wcnt_last) state_next = ISSUE;
            ISSUE:   if (rcnt_last) state_next = WAIT;
            WAIT:    if (pe_out_en || tmo_hit) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            step_q  <= '0;
            bound_q <= '0;
            bias_q  <= '0;
            wcnt    <= '0;
            rcnt    <= '0;
            tcnt    <= '0;
        end else begin
            state <= state_next;
            if (cfg_fire) begin
                step_q  <= cfg_step;
                bound_q <= cfg_bound;
                bias_q  <= cfg_bias;
                wcnt    <= '0;
                rcnt    <= '0;
            end
            // The last write holds wcnt so the index never wraps inside a group.
            if (chk_fire && !wcnt_last) begin
                wcnt <= wcnt + 1'b1;
            end
            if (state == ISSUE) begin
                if (rcnt_last) begin
                    tcnt <= '0;
                end else begin
                    rcnt <= rcnt + 1'b1;
                end
            end
            if (state == WAIT && !tmo_hit) begin
                tcnt <= tcnt + 1'b1;
            end
        end
    end

    // The PE drops its accumulation on any en gap, so pe_en tracks ISSUE exactly.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pe_en     <= 1'b0;
            pe_in     <= '0;
            pe_weight <= '0;
            pe_bias   <= '0;
            pe_bound  <= '0;
            pe_step   <= '0;
        end else begin
            pe_en <= (state == ISSUE);
            if (state == ISSUE) begin
                pe_in     <= rd_data[2*CHUNK_W-1:CHUNK_W];
                pe_weight <= rd_data[CHUNK_W-1:0];
                pe_bias   <= bias_q;
                pe_bound  <= bound_q;
                pe_step   <= step_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            err       <= 1'b0;
        end else begin
            if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end
            if (state == WAIT) begin
                if (pe_out_en) begin
                    res_data  <= pe_out;
                    res_valid <= 1'b1;
                end else if (tmo_hit) begin
                    err <= 1'b1;
                end
            end else if (pe_out_en) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pe_group_feeder.sv
// Self-checking bench for pe_group_feeder paired with a behavioural PE that
// accumulates signed 3x3 dot products over step+1 contiguous en cycles.
module tb_pe_group_feeder;
    import pe_group_feeder_pkg::*;

    localparam int TMO = 4;

    logic               clk;
    logic               reset;
    logic               cfg_valid;
    logic               cfg_ready;
    logic [2:0]         cfg_step;
    logic [2:0]         cfg_bound;
    logic [BIAS_W-1:0]  cfg_bias;
    logic               chk_valid;
    logic               chk_ready;
    logic [CHUNK_W-1:0] chk_in;
    logic [CHUNK_W-1:0] chk_weight;
    logic [CHUNK_W-1:0] pe_in;
    logic [CHUNK_W-1:0] pe_weight;
    logic [BIAS_W-1:0]  pe_bias;
    logic [2:0]         pe_bound;
    logic [2:0]         pe_step;
    logic               pe_en;
    logic [OUT_W-1:0]   pe_out;
    logic               pe_out_en;
    logic               res_valid;
    logic               res_ready;
    logic [OUT_W-1:0]   res_data;
    logic               err;

    logic pe_out_en_model;
    logic pe_mute;
    logic pe_force;
    assign pe_out_en = (pe_out_en_model && !pe_mute) || pe_force;

    pe_group_feeder #(
        .MAX_CHUNK (8),
        .TMO       (TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_step   (cfg_step),
        .cfg_bound  (cfg_bound),
        .cfg_bias   (cfg_bias),
        .chk_valid  (chk_valid),
        .chk_ready  (chk_ready),
        .chk_in     (chk_in),
        .chk_weight (chk_weight),
        .pe_in      (pe_in),
        .pe_weight  (pe_weight),
        .pe_bias    (pe_bias),
        .pe_bound   (pe_bound),
        .pe_step    (pe_step),
        .pe_en      (pe_en),
        .pe_out     (pe_out),
        .pe_out_en  (pe_out_en),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    function automatic int cell_dot(input logic [CHUNK_W-1:0] a, input logic [CHUNK_W-1:0] w);
        int s;
        s = 0;
        for (int c = 0; c < N_CELL; c++) begin
            s += int'($signed(a[c*CELL_BIT +: CELL_BIT])) * int'($signed(w[c*CELL_BIT +: CELL_BIT]));
        end
        return s;
    endfunction

    function automatic logic [OUT_W-1:0] pe_func(input int sum, input logic [2:0] bound, input logic [BIAS_W-1:0] bias);
        int v;
        v = (sum + int'($signed(bias))) >>> bound;
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        return v[OUT_W-1:0];
    endfunction

    // Behavioural PE: counts contiguous en cycles, answers two cycles after the last.
    int               pe_cnt = 0;
    int               pe_acc = 0;
    bit               fire_now, fire_d1 = 0;
    logic [OUT_W-1:0] res_now, res_d1 = '0;
    initial begin
        pe_out_en_model = 1'b0;
        pe_out = '0;
    end
    always @(posedge clk) begin
        fire_now = 0;
        res_now = '0;
        if (pe_en === 1'b1) begin
            if (pe_cnt == 0) pe_acc = 0;
            pe_acc += cell_dot(pe_in, pe_weight);
            pe_cnt++;
            if (pe_cnt == int'(pe_step) + 1) begin
                fire_now = 1;
                res_now = pe_func(pe_acc, pe_bound, pe_bias);
                pe_cnt = 0;
            end
        end else begin
            pe_cnt = 0;
        end
        #1;
        pe_out_en_model = fire_d1;
        pe_out = res_d1;
        fire_d1 = fire_now;
        res_d1 = res_now;
    end

    logic [2:0]         g_step;
    logic [2:0]         g_bound;
    logic [BIAS_W-1:0]  g_bias;
    logic [CHUNK_W-1:0] g_in [8];
    logic [CHUNK_W-1:0] g_w  [8];
    logic [CHUNK_W-1:0] obs_in [8];
    logic [CHUNK_W-1:0] obs_w  [8];
    int obs_n, obs_first, obs_last, res_cyc, err_cyc;
    bit obs_gap, obs_cfg_ok;

    function automatic logic [OUT_W-1:0] ref_result();
        int s;
        s = 0;
        for (int i = 0; i <= int'(g_step); i++) s += cell_dot(g_in[i], g_w[i]);
        return pe_func(s, g_bound, g_bias);
    endfunction

    function automatic bit order_ok();
        bit ok;
        ok = 1;
        for (int i = 0; i <= int'(g_step); i++) begin
            if (obs_in[i] !== g_in[i] || obs_w[i] !== g_w[i]) ok = 0;
        end
        return ok;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_chunks();
        for (int i = 0; i < 8; i++) begin
            for (int c = 0; c < N_CELL; c++) begin
                g_in[i][c*CELL_BIT +: CELL_BIT] = 8'($urandom);
                g_w[i][c*CELL_BIT +: CELL_BIT]  = 8'($urandom);
            end
        end
    endtask

    task automatic send_group(input logic [2:0] step, input logic [2:0] bound,
                              input logic [BIAS_W-1:0] bias, input bit gaps);
        int n;
        g_step = step;
        g_bound = bound;
        g_bias = bias;
        cfg_step = step;
        cfg_bound = bound;
        cfg_bias = bias;
        cfg_valid = 1'b1;
        n = 0;
        while (!cfg_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("[TB] FAIL cfg_accept: cfg_ready never rose, required 1");
        end
        tick();
        cfg_valid = 1'b0;
        for (int i = 0; i <= int'(step); i++) begin
            if (gaps) begin
                chk_valid = 1'b0;
                tick();
            end
            chk_valid = 1'b1;
            chk_in = g_in[i];
            chk_weight = g_w[i];
            n = 0;
            while (!chk_ready && n < 50) begin
                tick();
                n++;
            end
            if (n >= 50) begin
                checks++;
                errors++;
                $display("[TB] FAIL chk_accept: chk_ready never rose for chunk %0d", i);
            end
            tick();
        end
        chk_valid = 1'b0;
    endtask

    task automatic observe(input int budget);
        obs_n = 0;
        obs_first = -1;
        obs_last = -1;
        res_cyc = -1;
        err_cyc = -1;
        obs_gap = 0;
        obs_cfg_ok = 1;
        for (int k = 0; k < budget; k++) begin
            if (pe_en === 1'b1) begin
                if (obs_n > 0 && cyc != obs_last + 1) obs_gap = 1;
                if (obs_n == 0) obs_first = cyc;
                obs_last = cyc;
                if (obs_n < 8) begin
                    obs_in[obs_n] = pe_in;
                    obs_w[obs_n] = pe_weight;
                end
                if (pe_bias !== g_bias || pe_bound !== g_bound || pe_step !== g_step) obs_cfg_ok = 0;
                obs_n++;
            end
            if (res_valid === 1'b1) begin
                res_cyc = cyc;
                break;
            end
            if (err === 1'b1) begin
                err_cyc = cyc;
                break;
            end
            tick();
        end
    endtask

    task automatic consume();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_cfg_ready_low: got %b want 0", cfg_ready); end
        checks++; if (pe_en !== 1'b0) begin errors++; $display("[TB] FAIL rst_pe_en: got %b want 0", pe_en); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_res_valid: got %b want 0", res_valid); end
        checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL rst_err: got %b want 0", err); end
        reset = 1'b1;
        tick();
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_cfg_ready_idle: got %b want 1", cfg_ready); end
        checks++; if (chk_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_chk_ready: got %b want 0", chk_ready); end
        checks++; if (pe_in !== '0 || pe_weight !== '0) begin errors++; $display("[TB] FAIL rst_pe_data: got %h want 0", pe_in); end
        checks++; if (pe_bias !== '0 || pe_step !== '0 || pe_bound !== '0) begin errors++; $display("[TB] FAIL rst_pe_cfg: bias %h step %0d want 0", pe_bias, pe_step); end
        checks++; if (res_data !== '0) begin errors++; $display("[TB] FAIL rst_res_data: got %h want 0", res_data); end
    endtask

    task automatic test_single();
        g_in[0] = {N_CELL{8'h01}};
        g_w[0]  = {N_CELL{8'h01}};
        send_group(3'd0, 3'd0, 16'd0, 0);
        observe(40);
        checks++; if (obs_n != 1) begin errors++; $display("[TB] FAIL single_en_count: got %0d want 1", obs_n); end
        checks++; if (!order_ok()) begin errors++; $display("[TB] FAIL single_data: got %h want %h", obs_in[0], g_in[0]); end
        checks++; if (res_cyc != obs_first + 3) begin errors++; $display("[TB] FAIL single_latency: got %0d want %0d", res_cyc, obs_first + 3); end
        checks++; if (res_data !== 8'd9) begin errors++; $display("[TB] FAIL single_result: got %0d want 9", res_data); end
        consume();
        checks++; if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_clear: got %b want 0", res_valid); end
    endtask

    task automatic test_gaps();
        randomize_chunks();
        send_group(3'd2, 3'd1, 16'(-20), 1);
        observe(40);
        checks++; if (obs_n != 3) begin errors++; $display("[TB] FAIL gaps_en_count: got %0d want 3", obs_n); end
        checks++; if (obs_gap) begin errors++; $display("[TB] FAIL gaps_contiguous: got gap want none"); end
        checks++; if (!order_ok()) begin errors++; $display("[TB] FAIL gaps_order: got %h want %h", obs_in[0], g_in[0]); end
        checks++; if (!obs_cfg_ok) begin errors++; $display("[TB] FAIL gaps_pe_cfg: got bias %h want %h", pe_bias, g_bias); end
        checks++; if (res_cyc != obs_first + 5) begin errors++; $display("[TB] FAIL gaps_latency: got %0d want %0d", res_cyc, obs_first + 5); end
        checks++; if (res_data !== ref_result()) begin errors++; $display("[TB] FAIL gaps_result: got %h want %h", res_data, ref_result()); end
        consume();
    endtask

    task automatic test_backpressure();
        logic [OUT_W-1:0] held;
        bit ok;
        randomize_chunks();
        send_group(3'd1, 3'd0, 16'd7, 0);
        observe(40);
        held = ref_result();
        checks++; if (res_data !== held) begin errors++; $display("[TB] FAIL bp_result: got %h want %h", res_data, held); end
        cfg_valid = 1'b1;
        ok = 1;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (cfg_ready !== 1'b0 || chk_ready !== 1'b0 || res_valid !== 1'b1 || res_data !== held) ok = 0;
        end
        checks++; if (!ok) begin errors++; $display("[TB] FAIL bp_hold: cfg_ready %b res_valid %b data %h want 0/1/%h", cfg_ready, res_valid, res_data, held); end
        cfg_valid = 1'b0;
        consume();
        checks++; if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_clear: got %b want 0", res_valid); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_cfg_ready: got %b want 1", cfg_ready); end
    endtask

    task automatic test_random();
        logic [2:0] step;
        for (int g = 0; g < 6; g++) begin
            randomize_chunks();
            step = 3'($urandom_range(0, 7));
            send_group(step, 3'($urandom), 16'($urandom), bit'($urandom_range(0, 1)));
            observe(60);
            checks++; if (obs_n != int'(step) + 1) begin errors++; $display("[TB] FAIL rand%0d_en_count: got %0d want %0d", g, obs_n, step + 1); end
            checks++; if (obs_gap) begin errors++; $display("[TB] FAIL rand%0d_contiguous: got gap want none", g); end
            checks++; if (!order_ok() || !obs_cfg_ok) begin errors++; $display("[TB] FAIL rand%0d_stream: got %h want %h", g, obs_in[0], g_in[0]); end
            checks++; if (res_cyc != obs_first + int'(step) + 3) begin errors++; $display("[TB] FAIL rand%0d_latency: got %0d want %0d", g, res_cyc, obs_first + step + 3); end
            checks++; if (res_data !== ref_result()) begin errors++; $display("[TB] FAIL rand%0d_result: got %h want %h", g, res_data, ref_result()); end
            checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL rand%0d_err: got %b want 0", g, err); end
            consume();
        end
    endtask

    task automatic test_timeout();
        randomize_chunks();
        pe_mute = 1'b1;
        send_group(3'd1, 3'd2, 16'd3, 0);
        observe(60);
        checks++; if (obs_n != 2) begin errors++; $display("[TB] FAIL tmo_en_count: got %0d want 2", obs_n); end
        checks++; if (err_cyc != obs_first + 1 + 2 + TMO + 1) begin errors++; $display("[TB] FAIL tmo_err_cycle: got %0d want %0d", err_cyc, obs_first + 1 + 2 + TMO + 1); end
        checks++; if (res_cyc != -1 || res_valid !== 1'b0) begin errors++; $display("[TB] FAIL tmo_no_result: got res_valid %b want 0", res_valid); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("[TB] FAIL tmo_idle: got cfg_ready %b want 1", cfg_ready); end
        tick();
        pe_mute = 1'b0;
    endtask

    task automatic test_reset_midgroup();
        int n;
        int k;
        bit quiet;
        randomize_chunks();
        send_group(3'd7, 3'd0, 16'd0, 0);
        n = 0;
        k = 0;
        while (n < 3 && k < 40) begin
            if (pe_en === 1'b1) n++;
            if (n < 3) tick();
            k++;
        end
        checks++; if (n != 3) begin errors++; $display("[TB] FAIL mid_reach_issue: got %0d en cycles want 3", n); end
        reset = 1'b0;
        tick();
        checks++; if (pe_en !== 1'b0 || res_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_outputs: pe_en %b res_valid %b want 0/0", pe_en, res_valid); end
        reset = 1'b1;
        tick();
        checks++; if (cfg_ready !== 1'b1 || chk_ready !== 1'b0) begin errors++; $display("[TB] FAIL mid_release_idle: cfg_ready %b chk_ready %b want 1/0", cfg_ready, chk_ready); end
        checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL mid_err_cleared: got %b want 0", err); end
        quiet = 1;
        for (int j = 0; j < 15; j++) begin
            tick();
            if (res_valid !== 1'b0 || err !== 1'b0 || pe_en !== 1'b0) quiet = 0;
        end
        checks++; if (!quiet) begin errors++; $display("[TB] FAIL mid_no_stray: res_valid %b err %b want 0/0", res_valid, err); end
    endtask

    task automatic test_spurious();
        logic [OUT_W-1:0] held;
        randomize_chunks();
        send_group(3'd0, 3'd0, 16'd1, 0);
        observe(40);
        held = ref_result();
        checks++; if (res_valid !== 1'b1 || err !== 1'b0) begin errors++; $display("[TB] FAIL spur_pre: res_valid %b err %b want 1/0", res_valid, err); end
        pe_force = 1'b1;
        tick();
        pe_force = 1'b0;
        tick();
        checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL spur_err: got %b want 1", err); end
        checks++; if (res_valid !== 1'b1 || res_data !== held) begin errors++; $display("[TB] FAIL spur_result_kept: res_valid %b data %h want 1/%h", res_valid, res_data, held); end
        consume();
        tick();
        checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL spur_sticky: got %b want 1", err); end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b0;
        cfg_valid = 1'b0;
        cfg_step = '0;
        cfg_bound = '0;
        cfg_bias = '0;
        chk_valid = 1'b0;
        chk_in = '0;
        chk_weight = '0;
        res_ready = 1'b0;
        pe_mute = 1'b0;
        pe_force = 1'b0;
        g_step = '0;
        g_bound = '0;
        g_bias = '0;
        test_reset();
        test_single();
        test_gaps();
        test_backpressure();
        test_random();
        test_timeout();
        test_reset_midgroup();
        test_spurious();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
